// File: rtl/mimo_buf_pkg.sv
// rtl/mimo_buf_pkg.sv - shared read-FSM state type and default sizes for the MIMO frame buffer
package mimo_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_SEND_H = 2'd2,
        ST_SEND_Y = 2'd3
    } rd_state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_H_WORDS = 16;
    localparam int DEF_Y_WORDS = 8;

endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - simple dual-port sample store, synchronous write, combinational read
module sample_ram #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mimo_frame_buffer.sv
// rtl/mimo_frame_buffer.sv - ping-pong H/Y frame buffer feeding a MIMO decoder
module mimo_frame_buffer
    import mimo_buf_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int H_WORDS = DEF_H_WORDS,
    parameter int Y_WORDS = DEF_Y_WORDS
) (
    input  logic              CLOCK_50,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] h_in_r,
    input  logic [DATA_W-1:0] h_in_i,
    input  logic              h_in_valid,
    input  logic [DATA_W-1:0] y_in_r,
    input  logic [DATA_W-1:0] y_in_i,
    input  logic              y_in_valid,
    input  logic              dec_ready,
    output logic              start_decoder,
    output logic [DATA_W-1:0] H_out_r,
    output logic [DATA_W-1:0] H_out_i,
    output logic              H_out_valid,
    output logic [DATA_W-1:0] Y_out_r,
    output logic [DATA_W-1:0] Y_out_i,
    output logic              Y_out_valid,
    output logic              overflow_err,
    output logic [15:0]       frames_sent
);

    localparam int HI_W = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
    localparam int YI_W = (Y_WORDS > 1) ? $clog2(Y_WORDS) : 1;
    localparam int RI_W = (HI_W > YI_W) ? HI_W : YI_W;
    localparam logic [HI_W-1:0] H_LAST   = HI_W'(H_WORDS - 1);
    localparam logic [YI_W-1:0] Y_LAST   = YI_W'(Y_WORDS - 1);
    localparam logic [RI_W-1:0] H_LAST_R = RI_W'(H_WORDS - 1);
    localparam logic [RI_W-1:0] Y_LAST_R = RI_W'(Y_WORDS - 1);

    logic [HI_W-1:0] h_idx;
    logic [YI_W-1:0] y_idx;
    logic            h_done, y_done;
    logic            wr_ptr, rd_ptr;
    logic [1:0]      full;

    rd_state_t       state, state_n;
    logic [RI_W-1:0] rd_idx, idx_n;

    logic            bank_release, bank_fill, wr_free, h_we, y_we, drop;
    logic [2*DATA_W-1:0] h_rdata, y_rdata;

    // A bank being released this cycle may be refilled in the same cycle.
    assign bank_release = (state == ST_SEND_Y) && (rd_idx == Y_LAST_R);
    assign bank_fill    = h_done && y_done;
    assign wr_free      = !full[wr_ptr] || (bank_release && (rd_ptr == wr_ptr));
    assign h_we         = h_in_valid && !h_done && wr_free;
    assign y_we         = y_in_valid && !y_done && wr_free;
    assign drop         = (h_in_valid && !h_we) || (y_in_valid && !y_we);

    sample_ram #(.WIDTH(2*DATA_W), .ADDR_W(HI_W+1)) u_h_ram (
        .clk     (CLOCK_50),
        .wr_en   (h_we),
        .wr_addr ({wr_ptr, h_idx}),
        .wr_data ({h_in_r, h_in_i}),
        .rd_addr ({rd_ptr, idx_n[HI_W-1:0]}),
        .rd_data (h_rdata)
    );

    sample_ram #(.WIDTH(2*DATA_W), .ADDR_W(YI_W+1)) u_y_ram (
        .clk     (CLOCK_50),
        .wr_en   (y_we),
        .wr_addr ({wr_ptr, y_idx}),
        .wr_data ({y_in_r, y_in_i}),
        .rd_addr ({rd_ptr, idx_n[YI_W-1:0]}),
        .rd_data (y_rdata)
    );

    always_ff @(posedge CLOCK_50) begin
        if (sys_rst) begin
            h_idx        <= '0;
            y_idx        <= '0;
            h_done       <= 1'b0;
            y_done       <= 1'b0;
            wr_ptr       <= 1'b0;
            full         <= 2'b00;
            overflow_err <= 1'b0;
        end else begin
            if (bank_fill) begin
                h_idx  <= '0;
                y_idx  <= '0;
                h_done <= 1'b0;
                y_done <= 1'b0;
                wr_ptr <= ~wr_ptr;
            end else begin
                if (h_we) begin
                    if (h_idx == H_LAST) h_done <= 1'b1;
                    else                 h_idx  <= h_idx + 1'b1;
                end
                if (y_we) begin
                    if (y_idx == Y_LAST) y_done <= 1'b1;
                    else                 y_idx  <= y_idx + 1'b1;
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (bank_fill && (wr_ptr == 1'(b)))
                    full[b] <= 1'b1;
                else if (bank_release && (rd_ptr == 1'(b)))
                    full[b] <= 1'b0;
            end
            if (drop) overflow_err <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = rd_idx;
        case (state)
            ST_IDLE: begin
                if (full[rd_ptr] && dec_ready) state_n = ST_START;
            end
            ST_START: begin
                state_n = ST_SEND_H;
                idx_n   = '0;
            end
            ST_SEND_H: begin
                if (rd_idx == H_LAST_R) begin
                    state_n = ST_SEND_Y;
                    idx_n   = '0;
                end else begin
                    idx_n = rd_idx + 1'b1;
                end
            end
            ST_SEND_Y: begin
                if (bank_release) begin
                    state_n = ST_IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = rd_idx + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so data lines up with its valid.
    always_ff @(posedge CLOCK_50) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            rd_idx        <= '0;
            rd_ptr        <= 1'b0;
            frames_sent   <= '0;
            start_decoder <= 1'b0;
            H_out_valid   <= 1'b0;
            H_out_r       <= '0;
            H_out_i       <= '0;
            Y_out_valid   <= 1'b0;
            Y_out_r       <= '0;
            Y_out_i       <= '0;
        end else begin
            state         <= state_n;
            rd_idx        <= idx_n;
            start_decoder <= (state == ST_IDLE) && (state_n == ST_START);
            H_out_valid   <= (state_n == ST_SEND_H);
            Y_out_valid   <= (state_n == ST_SEND_Y);
            {H_out_r, H_out_i} <= (state_n == ST_SEND_H) ? h_rdata : '0;
            {Y_out_r, Y_out_i} <= (state_n == ST_SEND_Y) ? y_rdata : '0;
            if (bank_release) begin
                rd_ptr      <= ~rd_ptr;
                frames_sent <= frames_sent + 16'd1;
            end
        end
    end

endmodule

// File: doc/mimo_frame_buffer.md
MIMO_FRAME_BUFFER -- requirements
Module: mimo_frame_buffer

Interface
REQ-001 Parameter DATA_W, default 32: width of each real and imaginary sample part.
REQ-002 Parameter H_WORDS, default 16: complex H samples per frame.
REQ-003 Parameter Y_WORDS, default 8: complex Y samples per frame.
REQ-004 CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-005 sys_rst  in  1  reset; synchronous, active-high.
REQ-006 h_in_r, h_in_i  in  DATA_W each  incoming H sample.
REQ-007 h_in_valid  in  1  H sample present this cycle.
REQ-008 y_in_r, y_in_i  in  DATA_W each  incoming Y sample.
REQ-009 y_in_valid  in  1  Y sample present this cycle.
REQ-010 dec_ready  in  1  decoder idle and able to accept a new frame.
REQ-011 start_decoder  out  1  one-cycle frame-start pulse.
REQ-012 H_out_r, H_out_i, H_out_valid  out  DATA_W, DATA_W, 1  H stream to the decoder.
REQ-013 Y_out_r, Y_out_i, Y_out_valid  out  DATA_W, DATA_W, 1  Y stream to the decoder.
REQ-014 overflow_err  out  1  sticky flag: an input sample was dropped.
REQ-015 frames_sent  out  16  count of completed output frames.

Function
REQ-016 The block SHALL hold two banks (ping-pong); each bank stores H_WORDS H samples and Y_WORDS Y samples.
REQ-017 Writes SHALL go to the write bank at the H index (h_in_valid) and Y index (y_in_valid) independently; H and Y may interleave or coincide in any cycle.
REQ-018 The write bank SHALL become full the cycle after both index counters complete; the write pointer then toggles and both counters clear.
REQ-019 An H (Y) sample arriving after the H (Y) count for the current bank has completed, or while both banks are full, SHALL be dropped and SHALL set overflow_err.
REQ-020 The read FSM SHALL have states IDLE, START, SEND_H, SEND_Y.
REQ-021 IDLE -> START when the read bank is full and dec_ready=1; otherwise remain in IDLE.
REQ-022 START SHALL assert start_decoder for exactly one cycle, then go to SEND_H.
REQ-023 SEND_H SHALL output H samples in index order 0..H_WORDS-1, one per cycle, with H_out_valid=1, then go to SEND_Y.
REQ-024 SEND_Y SHALL output Y samples 0..Y_WORDS-1, one per cycle, with Y_out_valid=1.
REQ-025 After the last Y sample, SEND_Y SHALL clear the read bank's full flag, toggle the read pointer, increment frames_sent (wrapping at 2^16), and return to IDLE.
REQ-026 All outputs SHALL be registered; data outputs SHALL be zero whenever their valid is low.
REQ-027 Latency: with dec_ready=1 and the FSM in IDLE, start_decoder SHALL rise 2 cycles after the final sample of a frame is accepted.
REQ-028 A bank release and a bank fill in the same cycle SHALL both take effect; no sample is dropped.
REQ-029 dec_ready SHALL be sampled only in IDLE; deassertion mid-frame SHALL not pause the stream.

Reset
REQ-030 sys_rst SHALL return the FSM to IDLE, clear both full flags, pointers, index counters, overflow_err and frames_sent, and drive every output to 0.
REQ-031 Reset mid-frame SHALL abort the frame; bank contents need not be cleared.

Structure
REQ-032 Package mimo_buf_pkg SHALL hold the read-FSM state enum and default parameter constants.
REQ-033 One sub-module, sample_ram (simple dual-port, address = {bank, index}, 2*DATA_W wide), SHALL be instantiated twice: once for H and once for Y.

Verification
REQ-034 Load 16 H samples then 8 Y samples, dec_ready=1 -> start_decoder 2 cycles after the last Y; 16 H_out_valid cycles, then 8 Y_out_valid cycles, in order; frames_sent=1.
REQ-035 Send Y and H interleaved on the same cycles -> identical output order and values; overflow_err=0.
REQ-036 Load two frames with dec_ready=0, then a third H sample -> sample dropped, overflow_err=1; raising dec_ready streams frame A then frame B.
REQ-037 Send 17 H samples before any Y -> 17th dropped, overflow_err=1; frame outputs H 0..15 unchanged.
REQ-038 Assert sys_rst during SEND_H -> next cycle all outputs 0, FSM in IDLE; a fresh frame then streams correctly.
REQ-039 Send 65536 frames -> frames_sent wraps to 0.
